imu_spi_target: RTL
===================

IMU_SPI_TARGET -- requirements
Module: imu_spi_target

Interface
REQ-001 SHALL have parameters (name, default, meaning): WHO_AM_I_VAL, 8'h6C, value returned at address 0x0F; SYNC_STAGES, 2, synchronizer depth on SPC/CS/SDI.
REQ-002 SHALL have ports (name direction width meaning): clk input 1 system clock; single clock; all logic on rising edge of clk.
REQ-003 reset input 1 -- asynchronous, active-low.
REQ-004 SPC input 1 -- SPI serial clock from the initiator; idle high.
REQ-005 CS input 1 -- chip select, active low.
REQ-006 SDI input 1 -- serial data from the initiator.
REQ-007 SDO output 1 -- serial data to the initiator.
REQ-008 sample input 96 -- live IMU sample as data_t: pitch, roll, yaw, x, y, z, packed MSB-first in that order.
REQ-009 ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl output 8 each -- configuration register contents.
REQ-010 wr_strobe output 1 -- one-cycle pulse per committed register write; wr_addr output 7 and wr_data output 8 are valid in the same cycle.

Function
REQ-011 SHALL implement SPI mode 3: SDI sampled on SPC rising edge; SDO changed on SPC falling edge; all bytes MSB first.
REQ-012 SHALL synchronize SPC, CS and SDI through SYNC_STAGES flops and detect edges in the clk domain; correct operation is required only for clk >= 8x SPC.
REQ-013 FSM states: IDLE, CMD, WDATA, RDATA; a 3-bit bit counter and a 7-bit address pointer.
REQ-014 IDLE -> CMD on synchronized CS falling; bit counter cleared.
REQ-015 CMD: shift 8 SDI bits; bit7 = 1 means read, 0 means write; bits 6:0 load the pointer; on the 8th rising edge go to RDATA (read) or WDATA (write).
REQ-016 On read entry, SHALL snapshot sample into a 96-bit shadow register in the same cycle, so one burst returns one coherent sample.
REQ-017 RDATA: load the byte at the pointer into the shift register at the 8th rising edge of each byte; drive its bit7 on the next falling edge; pointer += 1 after each byte.
REQ-018 WDATA: after 8 bits, write the byte to the register at the pointer, pulse wr_strobe once, pointer += 1, and stay in WDATA for burst writes.
REQ-019 Pointer SHALL wrap from 0x7F to 0x00.
REQ-020 Read map:
  - 0x0F -> WHO_AM_I_VAL
  - 0x10 ctrl1_xl, 0x11 ctrl2_g, 0x13 ctrl4_c, 0x18 ctrl9_xl
  - 0x22..0x2D -> shadow bytes, low byte first per field: 0x22 pitch[7:0], 0x23 pitch[15:8], ... 0x2D z[15:8]
  - all other addresses -> 8'h00
REQ-021 Writes SHALL update only 0x10, 0x11, 0x13 and 0x18; writes to any other address are ignored but still pulse wr_strobe.
REQ-022 CS rising at any point SHALL return the FSM to IDLE within SYNC_STAGES+1 cycles, with these effects:
  - a partial byte is discarded, with no write and no strobe;
  - SDO is driven to 0;
  - the shadow register is retained.
REQ-023 SDO SHALL be 0 whenever the FSM is not in RDATA.
REQ-024 A CS falling edge and an SPC edge in the same synchronized cycle: CS handling takes priority, and the SPC edge is ignored.

Reset
REQ-025 While reset is low, all state SHALL take these values:
  - FSM IDLE; bit counter and pointer 0;
  - SDO 0, wr_strobe 0, wr_addr 0, wr_data 0;
  - shadow 0; all ctrl registers 8'h00.
REQ-026 Reset asserted mid-transaction SHALL abort it; the block SHALL wait for a fresh CS falling edge after reset releases.

Structure
REQ-027 data_t and all register address constants (0x0F, 0x10, 0x11, 0x13, 0x18, 0x22, 0x2D) SHALL live in shared package imu_pkg.
REQ-028 The synchronizer plus rise/fall detection for one pin SHALL be sub-module spi_pin_sync, instantiated three times.

Verification
REQ-029 Read WHO_AM_I: CS low, command 0x8F, 8 dummy clocks -> SDO returns 0x6C.
REQ-030 Write then read: 0x10 followed by 0x60 -> wr_strobe once with wr_addr 0x10 and wr_data 0x60; ctrl1_xl = 0x60; read 0x90 -> 0x60.
REQ-031 Burst read: sample pitch 16'h1234 ... z 16'hBEEF, command 0xA2, 96 clocks -> bytes 34 12 ... EF BE; changing sample mid-burst does not alter the bytes returned.
REQ-032 Abort: CS rises after 5 bits of the write data to 0x11 -> no wr_strobe and ctrl2_g unchanged; the next transaction works.
REQ-033 Wrap: read at 0x7F for 2 bytes -> 0x00, then the byte at address 0x00 (0x00).
REQ-034 Async reset: drive reset low mid-burst -> SDO 0 and ctrl registers 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/imu_pkg.sv
// Shared types, register map and read-mux helper for the IMU SPI target.
package imu_pkg;

   typedef struct packed {
      logic [15:0] pitch;
      logic [15:0] roll;
      logic [15:0] yaw;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } data_t;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StWdata,
      StRdata
   } spi_state_e;

   localparam logic [6:0] ADDR_WHO_AM_I     = 7'h0F;
   localparam logic [6:0] ADDR_CTRL1_XL     = 7'h10;
   localparam logic [6:0] ADDR_CTRL2_G      = 7'h11;
   localparam logic [6:0] ADDR_CTRL4_C      = 7'h13;
   localparam logic [6:0] ADDR_CTRL9_XL     = 7'h18;
   localparam logic [6:0] ADDR_SHADOW_FIRST = 7'h22;
   localparam logic [6:0] ADDR_SHADOW_LAST  = 7'h2D;

   // Byte of a sample at a shadow address; each 16-bit field is returned low byte first.
   function automatic logic [7:0] shadow_byte(input data_t d, input logic [6:0] addr);
      logic [3:0]  idx;
      logic [95:0] flat;
      int unsigned off;
      idx  = 4'(addr - ADDR_SHADOW_FIRST);
      flat = d;
      off  = 80 - 16 * int'(idx[3:1]) + 8 * int'(idx[0]);
      return flat[off +: 8];
   endfunction

   function automatic logic [7:0] reg_read(input logic [6:0] addr,
                                           input logic [7:0] who_am_i,
                                           input logic [7:0] ctrl1_xl,
                                           input logic [7:0] ctrl2_g,
                                           input logic [7:0] ctrl4_c,
                                           input logic [7:0] ctrl9_xl,
                                           input data_t      d);
      logic [7:0] val;
      val = 8'h00;
      case (addr)
         ADDR_WHO_AM_I: val = who_am_i;
         ADDR_CTRL1_XL: val = ctrl1_xl;
         ADDR_CTRL2_G:  val = ctrl2_g;
         ADDR_CTRL4_C:  val = ctrl4_c;
         ADDR_CTRL9_XL: val = ctrl9_xl;
         default: begin
            if (addr >= ADDR_SHADOW_FIRST && addr <= ADDR_SHADOW_LAST) begin
               val = shadow_byte(d, addr);
            end
         end
      endcase
      return val;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection in the clk domain.
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q[0] <= pin;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/imu_spi_target.sv
// SPI mode-3 register target for an IMU: config registers plus a coherent sample snapshot.
module imu_spi_target
   import imu_pkg::*;
#(
   parameter logic [7:0]  WHO_AM_I_VAL = 8'h6C,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SPC,
   input  logic       CS,
   input  logic       SDI,
   output logic       SDO,
   input  data_t      sample,
   output logic [7:0] ctrl1_xl,
   output logic [7:0] ctrl2_g,
   output logic [7:0] ctrl4_c,
   output logic [7:0] ctrl9_xl,
   output logic       wr_strobe,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data
);

   logic spc_level, spc_rise, spc_fall;
   logic cs_level, cs_rise, cs_fall;
   logic sdi_level, sdi_rise, sdi_fall;
   logic unused_sync;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_spc (
      .clk   (clk),
      .reset (reset),
      .pin   (SPC),
      .level (spc_level),
      .rise  (spc_rise),
      .fall  (spc_fall)
   );

   // CS resets to "asserted" so a CS already low at reset release is not seen as a new falling edge.
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
      .clk   (clk),
      .reset (reset),
      .pin   (CS),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
      .clk   (clk),
      .reset (reset),
      .pin   (SDI),
      .level (sdi_level),
      .rise  (sdi_rise),
      .fall  (sdi_fall)
   );

   assign unused_sync = ^{spc_level, cs_rise, sdi_rise, sdi_fall};

   spi_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] ptr_q, ptr_d;
   logic [6:0] shift_in_q, shift_in_d;
   logic [7:0] shift_out_q, shift_out_d;
   logic       sdo_q, sdo_d;
   data_t      shadow_q, shadow_d;
   logic [7:0] ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d, ctrl4_q, ctrl4_d, ctrl9_q, ctrl9_d;
   logic       wr_strobe_q, wr_strobe_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] rx_byte;
   logic [7:0] cmd_rd_byte, ptr_rd_byte;

   assign rx_byte = {shift_in_q, sdi_level};

   // First read byte comes from the live sample, which is the value being snapshotted this cycle.
   assign cmd_rd_byte = reg_read(rx_byte[6:0], WHO_AM_I_VAL, ctrl1_q, ctrl2_q, ctrl4_q, ctrl9_q,
                                 sample);
   assign ptr_rd_byte = reg_read(ptr_q, WHO_AM_I_VAL, ctrl1_q, ctrl2_q, ctrl4_q, ctrl9_q,
                                 shadow_q);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      ptr_d       = ptr_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      sdo_d       = sdo_q;
      shadow_d    = shadow_q;
      ctrl1_d     = ctrl1_q;
      ctrl2_d     = ctrl2_q;
      ctrl4_d     = ctrl4_q;
      ctrl9_d     = ctrl9_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (cs_fall) begin
         state_d   = StCmd;
         bit_cnt_d = '0;
      end else if (cs_level) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: ;
            StCmd: begin
               if (spc_rise) begin
                  shift_in_d = rx_byte[6:0];
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ptr_d = rx_byte[6:0];
                     if (rx_byte[7]) begin
                        state_d     = StRdata;
                        shadow_d    = sample;
                        shift_out_d = cmd_rd_byte;
                        ptr_d       = rx_byte[6:0] + 7'd1;
                     end else begin
                        state_d = StWdata;
                     end
                  end
               end
            end
            StWdata: begin
               if (spc_rise) begin
                  shift_in_d = rx_byte[6:0];
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = ptr_q;
                     wr_data_d   = rx_byte;
                     ptr_d       = ptr_q + 7'd1;
                     case (ptr_q)
                        ADDR_CTRL1_XL: ctrl1_d = rx_byte;
                        ADDR_CTRL2_G:  ctrl2_d = rx_byte;
                        ADDR_CTRL4_C:  ctrl4_d = rx_byte;
                        ADDR_CTRL9_XL: ctrl9_d = rx_byte;
                        default: ;
                     endcase
                  end
               end
            end
            StRdata: begin
               if (spc_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     shift_out_d = ptr_rd_byte;
                     ptr_d       = ptr_q + 7'd1;
                  end
               end else if (spc_fall) begin
                  sdo_d       = shift_out_q[7];
                  shift_out_d = {shift_out_q[6:0], 1'b0};
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (state_d != StRdata) begin
         sdo_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         ptr_q       <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         sdo_q       <= 1'b0;
         shadow_q    <= '0;
         ctrl1_q     <= 8'h00;
         ctrl2_q     <= 8'h00;
         ctrl4_q     <= 8'h00;
         ctrl9_q     <= 8'h00;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         ptr_q       <= ptr_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         sdo_q       <= sdo_d;
         shadow_q    <= shadow_d;
         ctrl1_q     <= ctrl1_d;
         ctrl2_q     <= ctrl2_d;
         ctrl4_q     <= ctrl4_d;
         ctrl9_q     <= ctrl9_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign SDO       = sdo_q;
   assign ctrl1_xl  = ctrl1_q;
   assign ctrl2_g   = ctrl2_q;
   assign ctrl4_c   = ctrl4_q;
   assign ctrl9_xl  = ctrl9_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
